// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port indices
// and the latched controller command.
package mem_arb_pkg;

    // Widest address/data the command register can carry (one 32-bit word per transaction)
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef struct packed {
        logic                  op_write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       gnt_vld
);

    // Combinational winner selection
    always_comb begin
        gnt_vld = |req;
        gnt     = PORT0;
        if (req == 2'b11) begin
            gnt = ~last;
        end else if (req == 2'b10) begin
            gnt = PORT1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SRAM controller between the MEM stage (port 0) and a secondary
// requester (port 1). The winning command is latched and held until the
// controller completes; a watchdog aborts transactions that never finish.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,  // must not exceed CMD_ADDR_W
    parameter int DATA_W  = 32,  // must not exceed CMD_DATA_W
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_r_en,
    input  logic              m0_w_en,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    input  logic              m1_r_en,
    input  logic              m1_w_en,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              mc_r_en,
    output logic              mc_w_en,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_wdata,
    input  logic [DATA_W-1:0] mc_rdata,
    input  logic              mc_ready,
    output logic              err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    cmd_t              cmd;
    logic              grant;
    logic              last;
    logic [CNT_W-1:0]  wd_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        ready_q;
    logic              err_q;
    logic              busy_q;

    logic [1:0]        req;
    logic              gnt_nxt;
    logic              gnt_vld;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req = {m1_r_en | m1_w_en, m0_r_en | m0_w_en};

    mem_arb_rr u_rr (
        .req     (req),
        .last    (last),
        .gnt     (gnt_nxt),
        .gnt_vld (gnt_vld)
    );

    // Route the prospective winner's command; write takes precedence over read
    always_comb begin
        sel_write = m0_w_en;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        if (gnt_nxt == PORT1) begin
            sel_write = m1_w_en;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    // Arbitration FSM with command register, watchdog and registered status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cmd     <= '0;
            grant   <= PORT0;
            last    <= PORT1;
            wd_cnt  <= '0;
            rdata_q <= '0;
            ready_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ready_q <= '0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        state        <= BUSY;
                        grant        <= gnt_nxt;
                        last         <= gnt_nxt;
                        cmd.op_write <= sel_write;
                        cmd.addr     <= CMD_ADDR_W'(sel_addr);
                        cmd.wdata    <= CMD_DATA_W'(sel_wdata);
                        wd_cnt       <= '0;
                        busy_q       <= 1'b1;
                    end
                end
                BUSY: begin
                    if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                    // Completion beats a coincident timeout
                    if (mc_ready) begin
                        state          <= DONE;
                        rdata_q        <= mc_rdata;
                        ready_q[grant] <= 1'b1;
                    end else if (wd_cnt == WD_LAST) begin
                        state  <= IDLE;
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign mc_r_en  = (state == BUSY) && !cmd.op_write;
    assign mc_w_en  = (state == BUSY) &&  cmd.op_write;
    assign mc_addr  = cmd.addr[ADDR_W-1:0];
    assign mc_wdata = cmd.wdata[DATA_W-1:0];

    assign m0_ready = ready_q[0];
    assign m1_ready = ready_q[1];
    assign m0_rdata = (grant == PORT0) ? rdata_q : '0;
    assign m1_rdata = (grant == PORT1) ? rdata_q : '0;

    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_r_en, m0_w_en, m1_r_en, m1_w_en;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        mc_r_en, mc_w_en;
    logic [31:0] mc_addr, mc_wdata, mc_rdata;
    logic        mc_ready;
    logic        err, busy;

    int checks = 0;
    int errors = 0;
    logic bad;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .m0_r_en(m0_r_en), .m0_w_en(m0_w_en), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_r_en(m1_r_en), .m1_w_en(m1_w_en), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .mc_r_en(mc_r_en), .mc_w_en(mc_w_en), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_rdata(mc_rdata), .mc_ready(mc_ready),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        m0_r_en = 0; m0_w_en = 0; m0_addr = '0; m0_wdata = '0;
        m1_r_en = 0; m1_w_en = 0; m1_addr = '0; m1_wdata = '0;
        mc_rdata = '0; mc_ready = 0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_mc_r_en", mc_r_en, 0);
        chk("rst_mc_w_en", mc_w_en, 0);
        chk("rst_mc_addr", mc_addr, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_ready", {m1_ready, m0_ready}, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        tick();

        // Single read, port 0, controller answers on the 4th BUSY edge
        m0_r_en = 1; m0_addr = 32'h40;
        tick();
        chk("rd_en_c1", mc_r_en, 1);
        chk("rd_addr", mc_addr, 32'h40);
        chk("rd_w_en", mc_w_en, 0);
        chk("rd_busy", busy, 1);
        tick(); chk("rd_en_c2", mc_r_en, 1);
        tick(); chk("rd_en_c3", mc_r_en, 1);
        tick(); chk("rd_en_c4", mc_r_en, 1);
        chk("rd_no_early_ready", m0_ready, 0);
        mc_ready = 1; mc_rdata = 32'hDEAD_BEEF;
        tick();
        chk("rd_m0_ready", m0_ready, 1);
        chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("rd_m1_ready", m1_ready, 0);
        chk("rd_m1_rdata", m1_rdata, 0);
        chk("rd_en_done", mc_r_en, 0);
        chk("rd_busy_done", busy, 1);
        mc_ready = 0; m0_r_en = 0;
        tick();
        chk("rd_ready_pulse", m0_ready, 0);
        chk("rd_idle_busy", busy, 0);
        chk("rd_addr_hold", mc_addr, 32'h40);

        // Single write, port 1, command held while the requester changes inputs
        m1_w_en = 1; m1_addr = 32'h10; m1_wdata = 32'h1234_5678;
        tick();
        chk("wr_w_en", mc_w_en, 1);
        chk("wr_r_en", mc_r_en, 0);
        chk("wr_addr", mc_addr, 32'h10);
        chk("wr_wdata", mc_wdata, 32'h1234_5678);
        m1_wdata = 32'hFFFF_0000; m1_addr = 32'h99;
        tick();
        chk("wr_wdata_hold", mc_wdata, 32'h1234_5678);
        chk("wr_addr_hold", mc_addr, 32'h10);
        mc_ready = 1;
        tick();
        chk("wr_m1_ready", m1_ready, 1);
        chk("wr_m0_ready", m0_ready, 0);
        chk("wr_w_en_done", mc_w_en, 0);
        mc_ready = 0; m1_w_en = 0;
        tick();
        chk("wr_ready_pulse", m1_ready, 0);

        // Contention after reset: port 0 first, then strict alternation
        rst = 0;
        tick();
        rst = 1;
        m0_r_en = 1; m0_addr = 32'h20;
        m1_w_en = 1; m1_addr = 32'h30; m1_wdata = 32'hA5A5_A5A5;
        tick();
        chk("ct_g1_addr", mc_addr, 32'h20);
        chk("ct_g1_r_en", mc_r_en, 1);
        mc_ready = 1; mc_rdata = 32'h1111_2222;
        tick();
        chk("ct_g1_m0_ready", m0_ready, 1);
        chk("ct_g1_m0_rdata", m0_rdata, 32'h1111_2222);
        chk("ct_g1_m1_ready", m1_ready, 0);
        mc_ready = 0;
        tick();
        chk("ct_idle_gap", busy, 0);
        chk("ct_idle_en", {mc_w_en, mc_r_en}, 0);
        tick();
        chk("ct_g2_addr", mc_addr, 32'h30);
        chk("ct_g2_w_en", mc_w_en, 1);
        chk("ct_g2_wdata", mc_wdata, 32'hA5A5_A5A5);
        mc_ready = 1;
        tick();
        chk("ct_g2_m1_ready", m1_ready, 1);
        chk("ct_g2_m0_ready", m0_ready, 0);
        mc_ready = 0;
        tick(); tick();
        chk("ct_g3_addr", mc_addr, 32'h20);
        chk("ct_g3_r_en", mc_r_en, 1);
        mc_ready = 1;
        tick();
        chk("ct_g3_m0_ready", m0_ready, 1);
        mc_ready = 0;
        tick(); tick();
        chk("ct_g4_addr", mc_addr, 32'h30);
        mc_ready = 1;
        tick();
        chk("ct_g4_m1_ready", m1_ready, 1);
        mc_ready = 0; m0_r_en = 0; m1_w_en = 0;
        tick();
        chk("ct_end_idle", busy, 0);

        // r_en and w_en together on port 0 mean write
        m0_r_en = 1; m0_w_en = 1; m0_addr = 32'h50; m0_wdata = 32'h0BAD_F00D;
        tick();
        chk("rw_w_en", mc_w_en, 1);
        chk("rw_r_en", mc_r_en, 0);
        chk("rw_wdata", mc_wdata, 32'h0BAD_F00D);
        mc_ready = 1;
        tick();
        chk("rw_m0_ready", m0_ready, 1);
        mc_ready = 0; m0_r_en = 0; m0_w_en = 0;
        tick();

        // Watchdog: controller never answers
        m1_r_en = 1; m1_addr = 32'h60;
        tick();
        chk("wd_grant", mc_r_en, 1);
        bad = 0;
        for (int i = 1; i < 64; i++) begin
            tick();
            if (err !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || busy !== 1'b1)
                bad = 1;
        end
        chk("wd_quiet_63", bad, 0);
        tick();
        chk("wd_err", err, 1);
        chk("wd_busy", busy, 0);
        chk("wd_no_ready", {m1_ready, m0_ready}, 0);
        chk("wd_en_drop", mc_r_en, 0);
        tick();
        chk("wd_err_pulse", err, 0);
        chk("wd_regrant", mc_r_en, 1);
        chk("wd_regrant_addr", mc_addr, 32'h60);
        mc_ready = 1;
        tick();
        chk("wd_retry_ready", m1_ready, 1);
        mc_ready = 0; m1_r_en = 0;
        tick();

        // Reset asserted during the 2nd BUSY cycle
        m0_r_en = 1; m0_addr = 32'h70;
        tick();
        tick();
        chk("rb_busy_pre", busy, 1);
        rst = 0; m0_r_en = 0; mc_ready = 1;
        #1;
        chk("rb_en_drop", mc_r_en, 0);
        chk("rb_busy_drop", busy, 0);
        chk("rb_ready", {m1_ready, m0_ready}, 0);
        chk("rb_addr", mc_addr, 0);
        tick();
        rst = 1; mc_ready = 0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (err !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || busy !== 1'b0)
                bad = 1;
        end
        chk("rb_silent", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single SRAM memory controller between the pipeline MEM stage (port 0) and a secondary requester (port 1, instruction-fetch or DMA). It owns the controller's request lines.
- Per request: grants one port, latches its command, and holds it stable until the controller signals completion.
- Returns read data and a one-cycle ready pulse to the winning port.
- Stall/freeze logic uses that pulse.
- A watchdog aborts transactions the controller never completes.

## Interface
Parameters:
- ADDR_W, 32, address width of requester and controller ports
- DATA_W, 32, data width (one 32-bit word per transaction)
- TIMEOUT, 64, cycles in BUSY before the watchdog aborts
- CNT_W, 7, watchdog counter width (must hold TIMEOUT)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- m0_r_en, m0_w_en  in  1 each  port 0 read/write request (level, held until m0_ready)
- m0_addr  in  ADDR_W  port 0 address
- m0_wdata  in  DATA_W  port 0 write data
- m0_rdata  out  DATA_W  port 0 read data, valid while m0_ready=1
- m0_ready  out  1  port 0 completion pulse
- m1_*  same set as m0_* for port 1
- mc_r_en, mc_w_en  out  1 each  controller command enables
- mc_addr  out  ADDR_W  controller address
- mc_wdata  out  DATA_W  controller write data
- mc_rdata  in  DATA_W  controller read data, valid with mc_ready
- mc_ready  in  1  controller completion pulse
- err  out  1  one-cycle pulse on watchdog abort
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, BUSY, DONE.
- A port is requesting when r_en|w_en.
- If r_en and w_en are both high on one port, the request is a write; r_en is ignored.
- In IDLE, the grant is decided combinationally from the requests:
  - With one requester, that port wins.
  - With both requesting, the winner is the port not granted last (round-robin).
  - The last-grant pointer resets to port 1, so port 0 wins the first tie.
- On the IDLE→BUSY edge the arbiter:
  - registers the winner in the grant register;
  - latches the winner's addr, wdata and op into the command register;
  - updates the last-grant pointer;
  - clears the watchdog counter.
- In BUSY:
  - mc_r_en/mc_w_en, mc_addr and mc_wdata are driven from the command register, stable for the whole transaction.
  - Requester input changes are ignored.
  - The watchdog counter increments each cycle.
- BUSY→DONE when mc_ready=1.
  - mc_rdata is captured into the read-data register.
  - Writes capture as well; the captured value is don't-care.
- BUSY→IDLE with an err pulse when the counter reaches TIMEOUT-1 without mc_ready.
  - No m*_ready is given; the aborted requester stays stalled and re-arbitrates from IDLE.
  - When mc_ready and timeout occur in the same cycle, mc_ready wins (DONE, no err).
- In DONE:
  - m<grant>_ready=1 for exactly one cycle, with m<grant>_rdata = captured data.
  - mc_* enables are 0.
  - Next state is IDLE unconditionally.
- The loser's ready stays 0 and its request remains pending.
- In IDLE, requests present are re-evaluated immediately. No back-to-back issue from DONE.
- m*_rdata for a non-granted port reads 0.
- Outputs in IDLE: mc_r_en=mc_w_en=0, mc_addr/mc_wdata hold their last value, m*_ready=0.

## Timing
- Reset (rst=0) immediately forces:
  - state IDLE;
  - all m*_ready, mc_r_en, mc_w_en, err and busy = 0;
  - mc_addr, mc_wdata, m*_rdata = 0;
  - last-grant = port 1, counter = 0.
- Reset mid-transaction drops mc enables at once. No ready or err is issued for the lost transaction.
- Request to mc enable: the request is sampled at edge N, and mc_r_en/mc_w_en are high from edge N.
- mc_ready to requester: mc_ready sampled at edge K, and m*_ready is high from K to K+1.
- Minimum transaction time = controller latency + 2 cycles. An idle-to-idle round trip with a 1-cycle controller is 3 cycles.
- Under continuous contention, port 0 and port 1 alternate strictly. Neither port waits more than one foreign transaction.
- The counter saturates and never wraps.

## Structure
- Package mem_arb_pkg: state enum (IDLE, BUSY, DONE), port index constants (PORT0=0, PORT1=1), and the cmd struct {op_write, addr, wdata}.
- One sub-module, mem_arb_rr: 2-way round-robin pick.
  - Inputs: req[1:0], last grant.
  - Output: grant index and grant-valid.
  - Purely combinational.
- The FSM, command register, watchdog and response mux stay in mem_arbiter.

## Test plan
- Single read, port 0: addr 0x0000_0040, controller returns 0xDEAD_BEEF after 4 cycles → mc_r_en high 4 cycles with mc_addr 0x40. m0_ready pulses once with m0_rdata 0xDEAD_BEEF; m1_ready stays 0.
- Single write, port 1: addr 0x10, wdata 0x1234_5678 → mc_w_en=1 with mc_wdata 0x1234_5678 held until mc_ready, then m1_ready pulse.
- Simultaneous requests after reset (m0 read 0x20, m1 write 0x30) → port 0 is served first, then port 1, which is granted in the IDLE cycle after DONE. With both held continuously, the next grants go 0, 1, 0.
- Both r_en and w_en high on port 0 → mc_w_en=1, mc_r_en=0.
- Controller never raises mc_ready, TIMEOUT=64 → err pulses exactly 64 cycles after grant, no m*_ready, FSM returns to IDLE and re-grants the still-pending port.
- rst asserted low in the 2nd BUSY cycle → mc enables, busy and ready drop to 0 immediately, and nothing pulses after release.
